// File: rtl/cache_array_mp.sv
// Multi-read-port cache array: byte-masked write port, combinational read ports
// with same-cycle write bypass, per-entry valid bits and an invalidate-all sweep.
module cache_array_mp #(
  parameter int unsigned width       = 256,
  parameter int unsigned cache_size  = 16,
  parameter int unsigned cache_index = 4,
  parameter int unsigned num_rd      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [cache_index-1:0]        windex,
  input  logic [width/8-1:0]            wmask,
  input  logic [width-1:0]              datain,
  input  logic [num_rd*cache_index-1:0] rindex,
  output logic [num_rd*width-1:0]       dataout,
  output logic [num_rd-1:0]             valid,
  input  logic                          inv_start,
  output logic                          ready,
  output logic                          inv_busy,
  output logic                          inv_done
);

  localparam int unsigned nb = width / 8;
  localparam logic [cache_index-1:0] last_idx = cache_index'(cache_size - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]             state, state_nx;
  logic [cache_index-1:0] cnt, cnt_nx;
  logic [cache_size-1:0]  vbit;
  logic [width-1:0]       mem [cache_size];
  logic                   we;

  assign ready    = (state != SWEEP);
  assign inv_busy = (state == SWEEP);
  assign inv_done = (state == DONE);
  assign we       = load && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Sweep sequencing; DONE can chain straight into a new sweep.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (inv_start) begin
          state_nx = SWEEP;
          cnt_nx   = '0;
        end
      end
      SWEEP: begin
        cnt_nx = cnt + cache_index'(1);
        if (cnt == last_idx) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end
      end
      DONE: begin
        if (inv_start) begin
          state_nx = SWEEP;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Sweep clears and writes are mutually exclusive since writes need ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbit <= '0;
    end else if (state == SWEEP) begin
      vbit[cnt] <= 1'b0;
    end else if (we) begin
      vbit[windex] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < nb; b++) begin
        if (wmask[b]) mem[windex][b*8 +: 8] <= datain[b*8 +: 8];
      end
    end
  end

  for (genvar p = 0; p < num_rd; p++) begin : g_rd
    logic [cache_index-1:0] ridx;
    logic                   hit;
    logic [width-1:0]       stored;
    logic [width-1:0]       rd;

    assign ridx   = rindex[p*cache_index +: cache_index];
    assign hit    = we && (ridx == windex);
    assign stored = vbit[ridx] ? mem[ridx] : '0;

    // Enabled bytes of an accepted same-index write override the stored entry.
    always_comb begin
      rd = stored;
      for (int b = 0; b < nb; b++) begin
        if (hit && wmask[b]) rd[b*8 +: 8] = datain[b*8 +: 8];
      end
    end

    assign dataout[p*width +: width] = rd;
    assign valid[p]                  = vbit[ridx] | hit;
  end

endmodule

// File: tb/tb_cache_array_mp.sv
// Self-checking bench for cache_array_mp: vector table, directed sweep/reset
// sequences and random traffic against a behavioural array model.
module tb_cache_array_mp;

  localparam int unsigned W  = 256;
  localparam int unsigned N  = 16;
  localparam int unsigned CI = 4;
  localparam int unsigned NR = 2;
  localparam int unsigned NB = W / 8;

  logic             clk, rst, load, inv_start;
  logic [CI-1:0]    windex;
  logic [NB-1:0]    wmask;
  logic [W-1:0]     datain;
  logic [NR*CI-1:0] rindex;
  logic [NR*W-1:0]  dataout;
  logic [NR-1:0]    valid;
  logic             ready, inv_busy, inv_done;

  int total, bad;

  // Model: contents, valid flags, remaining sweep cycles, done-pulse flag.
  logic [W-1:0] mdata [N];
  bit           mv    [N];
  int           sweep_left;
  bit           mdone;

  cache_array_mp #(.width(W), .cache_size(N), .cache_index(CI), .num_rd(NR)) dut (
    .clk(clk), .rst(rst), .load(load), .windex(windex), .wmask(wmask),
    .datain(datain), .rindex(rindex), .dataout(dataout), .valid(valid),
    .inv_start(inv_start), .ready(ready), .inv_busy(inv_busy), .inv_done(inv_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic          ld;
    logic [CI-1:0] wi;
    logic [NB-1:0] wm;
    logic [W-1:0]  din;
    logic [CI-1:0] r0, r1;
    logic          ev0, ev1;
    logic [W-1:0]  ed0, ed1;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit model_acc();
    return load && (sweep_left == 0);
  endfunction

  function automatic logic [W-1:0] exp_rd(input logic [CI-1:0] idx);
    logic [W-1:0] r;
    r = mv[idx] ? mdata[idx] : '0;
    if (model_acc() && idx == windex)
      for (int b = 0; b < NB; b++) if (wmask[b]) r[b*8 +: 8] = datain[b*8 +: 8];
    return r;
  endfunction

  function automatic bit exp_valid(input logic [CI-1:0] idx);
    return mv[idx] || (model_acc() && idx == windex);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mv[4'(i)] = 1'b0;
    sweep_left = 0;
    mdone = 1'b0;
  endtask

  function automatic logic [CI-1:0] rport(input int p);
    return rindex[p*CI +: CI];
  endfunction

  task automatic settle_check();
    #1;
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("dout%0d", p), dataout[p*W +: W], exp_rd(rport(p)));
      chk($sformatf("valid%0d", p), W'(valid[p]), W'(exp_valid(rport(p))));
    end
    chk("ready", W'(ready), W'(sweep_left == 0));
    chk("inv_busy", W'(inv_busy), W'(sweep_left != 0));
    chk("inv_done", W'(inv_done), W'(mdone));
  endtask

  task automatic tick();
    bit            acc, st;
    logic [CI-1:0] wi;
    logic [NB-1:0] wm;
    logic [W-1:0]  d;
    acc = model_acc();
    st  = inv_start;
    wi  = windex;
    wm  = wmask;
    d   = datain;
    @(posedge clk);
    if (acc) begin
      for (int b = 0; b < NB; b++) if (wm[b]) mdata[wi][b*8 +: 8] = d[b*8 +: 8];
      mv[wi] = 1'b1;
    end
    if (sweep_left > 0) begin
      mv[4'(N - sweep_left)] = 1'b0;
      sweep_left--;
      mdone = (sweep_left == 0);
    end else begin
      mdone = 1'b0;
      if (st) sweep_left = N;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    load = 1'b0; inv_start = 1'b0; windex = '0; wmask = '0; datain = '0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < N; i++) begin
      load = 1'b1; windex = 4'(i); wmask = '1; datain = rnd();
      settle_check();
      tick();
    end
    load = 1'b0;
  endtask

  task automatic start_sweep();
    inv_start = 1'b1;
    settle_check();
    tick();
    inv_start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a5, m3c, d;
    int busy_cnt, done_cnt;
    total = 0; bad = 0;
    for (int i = 0; i < N; i++) mdata[4'(i)] = '0;
    model_reset();
    idle_inputs();
    rindex = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state: every index invalid on both ports.
    for (int i = 0; i < N; i++) begin
      rindex = {4'(i), 4'(N - 1 - i)};
      settle_check();
      chk("rst_valid", W'(valid), W'(2'b00));
      chk("rst_dout", dataout[W-1:0] | dataout[2*W-1:W], '0);
      tick();
    end

    a5  = {32{8'hA5}};
    m3c = {{31{8'hA5}}, 8'h3C};
    tbl[0] = '{1'b1, 4'd3, {NB{1'b1}}, a5, 4'd3, 4'd4, 1'b1, 1'b0, a5, '0};
    tbl[1] = '{1'b0, 4'd3, {NB{1'b0}}, '0, 4'd3, 4'd4, 1'b1, 1'b0, a5, '0};
    tbl[2] = '{1'b1, 4'd3, NB'(1), W'(8'h3C), 4'd3, 4'd3, 1'b1, 1'b1, m3c, m3c};
    tbl[3] = '{1'b1, 4'd7, NB'(1), {{31{8'hFF}}, 8'h5E}, 4'd7, 4'd3, 1'b1, 1'b1, W'(8'h5E), m3c};
    tbl[4] = '{1'b0, 4'd0, {NB{1'b0}}, '0, 4'd3, 4'd3, 1'b1, 1'b1, m3c, m3c};
    for (int i = 0; i < 5; i++) begin
      load = tbl[i].ld; windex = tbl[i].wi; wmask = tbl[i].wm; datain = tbl[i].din;
      rindex = {tbl[i].r1, tbl[i].r0};
      settle_check();
      chk($sformatf("tbl%0d_v0", i), W'(valid[0]), W'(tbl[i].ev0));
      chk($sformatf("tbl%0d_v1", i), W'(valid[1]), W'(tbl[i].ev1));
      chk($sformatf("tbl%0d_d0", i), dataout[W-1:0], tbl[i].ed0);
      chk($sformatf("tbl%0d_d1", i), dataout[2*W-1:W], tbl[i].ed1);
      tick();
    end
    idle_inputs();

    // Full sweep: 16 busy cycles, idx 5 drops after sweep cycle 6, load dropped.
    fill_all();
    start_sweep();
    busy_cnt = 0;
    for (int k = 1; k <= 17; k++) begin
      load = (k == 3); windex = 4'd9; wmask = '1; datain = rnd();
      rindex = {4'(k % N), 4'd5};
      settle_check();
      if (inv_busy) busy_cnt++;
      if (k == 6) chk("idx5_last_valid", W'(valid[0]), W'(1'b1));
      if (k == 7) chk("idx5_cleared", W'(valid[0]), W'(1'b0));
      if (k == 17) chk("done_cycle17", W'(inv_done), W'(1'b1));
      tick();
    end
    idle_inputs();
    chk("busy_cycles", W'(busy_cnt), W'(16));
    rindex = {4'd9, 4'd9};
    settle_check();
    chk("dropped_load", W'(valid[0]), W'(1'b0));
    tick();

    // Back-to-back sweep with a write committed in the DONE cycle.
    start_sweep();
    for (int k = 1; k <= 16; k++) begin
      settle_check();
      tick();
    end
    d = rnd();
    inv_start = 1'b1; load = 1'b1; windex = 4'd2; wmask = '1; datain = d;
    rindex = {4'd0, 4'd2};
    settle_check();
    chk("b2b_done", W'(inv_done), W'(1'b1));
    chk("b2b_bypass", dataout[W-1:0], d);
    tick();
    idle_inputs();
    for (int k = 1; k <= 17; k++) begin
      settle_check();
      if (k == 1) chk("b2b_no_idle", W'(inv_busy), W'(1'b1));
      if (k == 3) chk("b2b_idx2_held", W'(valid[0]), W'(1'b1));
      if (k == 4) chk("b2b_idx2_clr", W'(valid[0]), W'(1'b0));
      tick();
    end

    // Asynchronous reset at sweep cycle 8.
    fill_all();
    start_sweep();
    rindex = {4'd12, 4'd10};
    for (int k = 1; k <= 7; k++) begin
      settle_check();
      tick();
    end
    settle_check();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_ready", W'(ready), W'(1'b1));
    chk("arst_busy", W'(inv_busy), W'(1'b0));
    chk("arst_done", W'(inv_done), W'(1'b0));
    chk("arst_valid", W'(valid), W'(2'b00));
    chk("arst_dout", dataout[W-1:0] | dataout[2*W-1:W], '0);
    @(posedge clk);
    @(negedge clk);
    settle_check();
    rst = 1'b0;
    d = rnd();
    load = 1'b1; windex = 4'd12; wmask = '1; datain = d;
    settle_check();
    tick();
    idle_inputs();
    settle_check();
    chk("rt_valid", W'(valid[1]), W'(1'b1));
    chk("rt_data", dataout[2*W-1:W], d);
    tick();
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      settle_check();
      if (inv_done) done_cnt++;
      tick();
    end
    chk("no_done_after_rst", W'(done_cnt), W'(0));

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      load = 1'($urandom_range(0, 1));
      windex = 4'($urandom_range(0, N - 1));
      case ($urandom_range(0, 3))
        0: wmask = '0;
        1: wmask = '1;
        default: wmask = NB'($urandom);
      endcase
      datain = rnd();
      rindex = {4'($urandom_range(0, N - 1)), ($urandom_range(0, 1) == 1) ? windex : 4'($urandom_range(0, N - 1))};
      inv_start = ($urandom_range(0, 24) == 0);
      settle_check();
      tick();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_array_mp.md
Name: cache_array_mp

Overview:
- Parametrised successor to the single-port cache data/tag array.
- Single write port with byte enables, NUM_RD independent combinational read ports, and a per-entry valid bit.
- Same-cycle write-to-read bypass that merges the enabled bytes.
- Built-in sequential invalidate-all sweep engine.
- Used for cache data, tag and metadata arrays, and for multi-read-port structures in the OoO core.

Parameters:
- width, 256: entry width in bits; must be a multiple of 8.
- cache_size, 16: number of entries.
- cache_index, 4: log2(cache_size); index width.
- num_rd, 2: number of read ports, 1 or more.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  write request.
- windex  in  cache_index  write index.
- wmask  in  width/8  byte enables; bit b covers datain[8b+7:8b].
- datain  in  width  write data.
- rindex  in  num_rd*cache_index  read indices; port p occupies slice [p*cache_index +: cache_index].
- dataout  out  num_rd*width  read data; port p occupies slice [p*width +: width].
- valid  out  num_rd  per-port valid bit of the addressed entry.
- inv_start  in  1  pulse that starts an invalidate-all sweep.
- ready  out  1  high when writes are accepted (not sweeping).
- inv_busy  out  1  sweep in progress.
- inv_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Storage
  - Data array is not reset.
  - Valid bits vbit[cache_size-1:0] reset asynchronously to 0.
- Reset state
  - FSM = IDLE, sweep counter = 0.
  - ready=1, inv_busy=0, inv_done=0.
  - All valid outputs = 0 and all dataout = 0 (because every entry is invalid).
- Write
  - Accepted when load && ready.
  - On the clk edge, for each byte b with wmask[b]=1: data[windex] byte b <= datain byte b. Bytes with wmask[b]=0 are unchanged.
  - vbit[windex] <= 1, even when wmask is all zeros.
  - load while ready=0 is dropped silently: no data change, no valid change.
- Read (combinational, per port p, zero latency)
  - Without bypass: if vbit[rindex_p]=1, dataout_p = data[rindex_p] and valid_p = 1. Otherwise dataout_p = 0 and valid_p = 0.
  - Bypass applies when the write is accepted and rindex_p == windex. Then valid_p = 1, and dataout_p byte b is:
    - datain byte b when wmask[b]=1;
    - otherwise the stored byte if vbit=1;
    - otherwise 0.
  - All ports evaluate independently. Any ports may share an index.
- Sweep FSM
  - IDLE:
    - inv_start=1 -> go to SWEEP, counter=0.
    - A write accepted in the same cycle as inv_start still commits, and its vbit set still occurs.
  - SWEEP:
    - Each cycle: vbit[counter] <= 0, then counter++.
    - ready=0, inv_busy=1.
    - When counter == cache_size-1, that entry is cleared, then go to DONE.
    - inv_start is ignored while in SWEEP.
    - Sweep length is exactly cache_size cycles.
  - DONE (one cycle):
    - inv_done=1, inv_busy=0, ready=1. Writes are accepted in this cycle.
    - inv_start=1 -> go to SWEEP again with counter=0. Otherwise -> IDLE.
- Reads during a sweep
  - Read the current vbit. The entry being cleared this cycle still reads valid. It reads invalid from the next cycle.
  - No bypass during a sweep, because no write is accepted.
- Widths: counter is cache_index bits and wraps only via the FSM; no overflow path exists.
- Reset mid-sweep: immediate return to the reset state. The sweep is abandoned and inv_done does not pulse.
- Outputs: dataout and valid are combinational. ready, inv_busy and inv_done are decoded from the FSM state register, with no combinational path from inputs.

Test Plan:
- Reset, then read all indices on both ports -> valid=0 and dataout=0 everywhere; ready=1.
- Write idx 3, wmask all-ones, data 0xA5 repeated; next cycle read idx 3 on port0 and idx 4 on port1 -> port0 valid=1 with 0xA5 pattern; port1 valid=0 with 0.
- Idx 3 holds 0xA5 pattern; write idx 3 with wmask=0x0000_0001 and datain byte0=0x3C while port0 and port1 both read idx 3 in the same cycle -> both ports show byte0=0x3C and the rest 0xA5 in that cycle. Also write idx 7 (invalid) with wmask=0x1 while reading idx 7 -> byte0 valid, other bytes 0, valid=1.
- Fill all 16 entries, pulse inv_start:
  - inv_busy is high for exactly 16 cycles and ready=0 during them.
  - Reads of idx 5 go invalid in the cycle after the 6th sweep cycle.
  - inv_done pulses in cycle 17.
  - A load during the sweep is dropped: that entry still reads invalid afterwards.
- Assert inv_start in the inv_done cycle -> a second sweep begins with no IDLE cycle in between; a concurrent write in the DONE cycle commits and is then cleared by the new sweep.
- Assert rst asynchronously (between clock edges) at sweep cycle 8 -> outputs return to the reset state immediately; inv_done never pulses; after rst deasserts, a write/read round-trip works normally.
